pipe_muldiv: RTL
================

PIPE_MULDIV -- requirements
Module: pipe_muldiv

Interface
REQ-001 SHALL have these ports, one per line as name, direction, width and meaning:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled on rising edge.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_data  input  32  operand A (dividend / multiplicand), taken from the register-file rs read port.
- rt_data  input  32  operand B (divisor / multiplier), taken from the register-file rt read port.
- mthi  input  1  write rs_data to HI.
- mtlo  input  1  write rs_data to LO.
- flush  input  1  synchronous abort of an in-flight operation.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when a result is committed.
- hi  output  32  HI register.
- lo  output  32  LO register.

Function
REQ-002 SHALL implement an FSM with the states IDLE, MUL, DIV and FIX; busy SHALL be high in MUL, DIV and FIX.
REQ-003 In IDLE, with start=1 at an edge: SHALL latch rs_data, rt_data and op, and enter MUL (op[1]=0) or DIV (op[1]=1).
REQ-004 SHALL store operand magnitudes for the signed ops MULT and DIV; 0x80000000 SHALL have magnitude 0x80000000 when treated as an unsigned 32-bit value.
- Sign flags: neg_res = A[31]^B[31]; neg_rem = A[31].
REQ-005 MUL SHALL run a radix-2 shift-add loop, one bit per cycle, for exactly 32 cycles into a 64-bit accumulator.
REQ-006 DIV SHALL run a radix-2 restoring division loop, one bit per cycle, for exactly 32 cycles, producing a 32-bit quotient and a 32-bit remainder.
REQ-007 An iteration counter SHALL count from 0 to 31; on the 32nd iteration the FSM SHALL enter FIX.
REQ-008 FIX SHALL last one cycle and SHALL apply the sign correction for signed ops:
- Multiply: 64-bit product negated when neg_res is set.
- Divide: quotient negated when neg_res is set; remainder negated when neg_rem is set.
REQ-009 FIX SHALL then write HI/LO and return to IDLE.
- Multiply: HI = product[63:32], LO = product[31:0].
- Divide: HI = remainder, LO = quotient.
REQ-010 Latency SHALL be fixed. If start is accepted at edge E:
- busy=1 after edges E through E+33.
- hi, lo updated and done=1 for one cycle after edge E+34.
- busy=0 after edge E+34.
REQ-011 Divide by zero (B=0) SHALL keep the full 34-cycle latency and commit HI = original rs_data and LO = 0xFFFFFFFF, for both DIV and DIVU.
REQ-012 DIV of 0x80000000 by 0xFFFFFFFF SHALL commit LO = 0x80000000 and HI = 0, with no exception.
REQ-013 start SHALL be ignored while busy=1; operands presented during that time SHALL NOT be latched.
REQ-014 mthi and mtlo SHALL write rs_data to HI and LO at the edge, only in IDLE with start=0.
- Both asserted: both registers written.
- start=1 in the same cycle: start takes priority and mthi/mtlo are ignored.
- busy=1: mthi/mtlo ignored.
REQ-015 flush=1 at an edge SHALL force the FSM to IDLE and leave HI/LO unchanged.
- No done is produced, including when flush coincides with FIX.
- When start=1 and flush=1 arrive in the same cycle in IDLE, flush SHALL win and nothing is accepted.
REQ-016 hi and lo SHALL be driven directly from the registers, with no combinational path from the inputs.
REQ-017 done SHALL be registered and SHALL never be high for two consecutive cycles.

Reset
REQ-018 reset=0 SHALL asynchronously force state=IDLE, the counter to 0, hi=0, lo=0, busy=0 and done=0, regardless of clk.
REQ-019 Reset asserted mid-operation SHALL discard the operation; no done SHALL follow after reset is released.
REQ-020 After reset is released, the first edge with start=1 SHALL be accepted normally.

Verification
REQ-021 MULTU, A=0xFFFFFFFF, B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 cycles after acceptance; busy high for 34 cycles.
REQ-022 MULT, A=0xFFFFFFFD (-3), B=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-023 DIV, A=0xFFFFFFF9 (-7), B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Also DIVU, A=7, B=0 -> hi=7, lo=0xFFFFFFFF.
REQ-024 mthi with rs_data=0x12345678, then MULTU 3x4 with flush=1 at iteration 10 -> hi stays 0x12345678; done never asserted; busy=0 the next cycle.
REQ-025 Start a DIVU, assert reset=0 at iteration 20 for 2 cycles -> hi=lo=0 and busy=0 immediately; no done within 40 cycles.
- Then a new MULTU 2x3 -> lo=6, hi=0.
REQ-026 start pulsed while busy with different operands -> the original result is committed unchanged and only one done pulse occurs.

Source files
------------

// File: rtl/pipe_muldiv_if.sv
// pipe_muldiv_if -- request/result bundle for the multiply/divide unit.
//   start, op, rs_data, rt_data : operation request and operands
//   mthi, mtlo                  : direct writes of rs_data into HI / LO
//   flush                       : synchronous abort of an in-flight operation
//   busy, done, hi, lo          : status and the architectural HI/LO registers
// master drives requests (pipeline / testbench); slave is the unit itself.
interface pipe_muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        mthi;
  logic        mtlo;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_data, rt_data, mthi, mtlo, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, mthi, mtlo, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/pipe_muldiv.sv
// pipe_muldiv -- iterative MIPS-style multiply/divide unit with HI/LO.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : pipe_muldiv_if.slave (start/op/operands/mthi/mtlo/flush in,
//           busy/done/hi/lo out)
// op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Each operation takes 34 busy
// cycles: one operand-conditioning cycle, 32 radix-2 iterations and one
// sign-fix cycle, after which HI/LO are written and done pulses.
module pipe_muldiv (
  input  logic         clk,
  input  logic         reset,
  pipe_muldiv_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        prep;      // first cycle after acceptance: convert to magnitudes
  logic [1:0]  op_q;
  logic        neg_res;
  logic        neg_rem;
  logic        b_zero;
  logic [31:0] a_orig;    // raw rs_data, kept for the divide-by-zero result
  logic [31:0] b_reg;     // multiplicand (MUL) or divisor (DIV) magnitude
  logic [31:0] acc_hi;    // product high half / partial remainder
  logic [31:0] acc_lo;    // multiplier shifting out / dividend-quotient
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;

  logic        is_signed;
  logic        is_div;
  logic [32:0] add_sum;
  logic [32:0] trial;
  logic [63:0] prod;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude.
  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

  assign is_signed = ~op_q[0];
  assign is_div    = op_q[1];

  // Shift-add step: add multiplicand when the current multiplier bit is set.
  assign add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_reg} : 33'd0);

  // Restoring step: shift in the next dividend bit and try the subtraction.
  // Bit 32 set means the shifted remainder is below the divisor.
  assign trial = {acc_hi, acc_lo[31]} - {1'b0, b_reg};

  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = (is_signed && neg_res) ? (~prod + 64'd1)   : prod;
  assign quo_fix  = (is_signed && neg_res) ? (~acc_lo + 32'd1) : acc_lo;
  assign rem_fix  = (is_signed && neg_rem) ? (~acc_hi + 32'd1) : acc_hi;

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  // NOTE: all state here is updated with non-blocking assignments so every
  // register sees the pre-edge values of the others, as real flops do.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      prep    <= 1'b0;
      op_q    <= 2'b00;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
      a_orig  <= 32'd0;
      b_reg   <= 32'd0;
      acc_hi  <= 32'd0;
      acc_lo  <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush) begin
        // Abort wins over everything, including a start or a pending FIX.
        state  <= IDLE;
        cnt    <= 5'd0;
        prep   <= 1'b0;
        busy_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              op_q    <= bus.op;
              a_orig  <= bus.rs_data;
              b_reg   <= bus.rt_data;
              neg_res <= bus.rs_data[31] ^ bus.rt_data[31];
              neg_rem <= bus.rs_data[31];
              b_zero  <= (bus.rt_data == 32'd0);
              cnt     <= 5'd0;
              prep    <= 1'b1;
              busy_q  <= 1'b1;
              state   <= bus.op[1] ? DIV : MUL;
            end else begin
              if (bus.mthi) hi_q <= bus.rs_data;
              if (bus.mtlo) lo_q <= bus.rs_data;
            end
          end
          MUL, DIV: begin
            if (prep) begin
              prep   <= 1'b0;
              acc_hi <= 32'd0;
              if (is_div) begin
                acc_lo <= mag(a_orig, is_signed);
                b_reg  <= mag(b_reg, is_signed);
              end else begin
                acc_lo <= mag(b_reg, is_signed);
                b_reg  <= mag(a_orig, is_signed);
              end
            end else begin
              if (state == MUL) begin
                {acc_hi, acc_lo} <= {add_sum, acc_lo[31:1]};
              end else if (!trial[32]) begin
                acc_hi <= trial[31:0];
                acc_lo <= {acc_lo[30:0], 1'b1};
              end else begin
                acc_hi <= {acc_hi[30:0], acc_lo[31]};
                acc_lo <= {acc_lo[30:0], 1'b0};
              end
              cnt <= cnt + 5'd1;
              if (cnt == 5'd31) state <= FIX;
            end
          end
          FIX: begin
            if (!is_div) begin
              hi_q <= prod_fix[63:32];
              lo_q <= prod_fix[31:0];
            end else if (b_zero) begin
              hi_q <= a_orig;
              lo_q <= 32'hFFFF_FFFF;
            end else begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
